aplic_msi_sched: RTL and testbench

- MSI delivery scheduler for an APLIC domain running in MSI delivery mode (domaincfg.dm=1).
- Selects one pending-and-enabled source per transaction, or one queued genmsi request, and forms the MSI address and data.
- Issues that write on a valid/ready channel towards the bus master, then tells the interrupt-pending logic which bit to clear.
- Sits between the register file (pending/enable/target/msiaddrcfg/genmsi state) and the AXI/bus write adapter.

---
 rtl/aplic_pkg.sv | 24 ++
 rtl/aplic_rr_picker.sv | 33 +++
 rtl/aplic_msi_sched.sv | 183 ++++++++++++++++++
 tb/tb_aplic_msi_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aplic_pkg.sv
// Shared types and constants for the APLIC MSI delivery path.
package aplic_pkg;

    localparam int APLIC_HART_IDX_W = 14;
    localparam int APLIC_EIID_W     = 11;
    localparam int MSI_PAGE_SHIFT   = 12;

    typedef logic [APLIC_HART_IDX_W-1:0] hart_index_t;
    typedef logic [APLIC_EIID_W-1:0]     eiid_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } msi_sched_state_e;

    // One candidate MSI: either a source (is_gen=0, src=k) or the genmsi slot.
    typedef struct packed {
        hart_index_t hi;
        eiid_t       eiid;
        logic        is_gen;
        logic [9:0]  src;
    } msi_req_t;

endpackage

// File: rtl/aplic_rr_picker.sv
// Rotating priority encoder: the first set request at or after ptr wins,
// wrapping at NR_SRC. With a constant ptr it collapses to a plain priority
// encoder.
module aplic_rr_picker #(
    parameter int NR_SRC = 32,
    parameter int IDX_W  = $clog2(NR_SRC)
) (
    input  logic [NR_SRC-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    int j;

    // Scan from the farthest offset down so the nearest request overwrites last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int off = NR_SRC - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= NR_SRC) begin
                j = j - NR_SRC;
            end
            if (req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/aplic_msi_sched.sv
// APLIC MSI delivery scheduler: picks the genmsi slot or one eligible source,
// issues the MSI write on a valid/ready channel and then pulses a
// pending-clear for the source that was delivered.
// Build option: APLIC_MSI_SCHED_RR_EN selects rotating priority among sources;
// when undefined the lowest eligible index wins and no pointer is kept.
//
//   state | meaning
//   IDLE  | no write outstanding; a pick may happen this cycle
//   ISSUE | o_msi_valid held with stable addr/data until i_msi_ready
module aplic_msi_sched
    import aplic_pkg::*;
#(
    parameter int NR_SRC     = 32,
    parameter int HART_IDX_W = 14,
    parameter int EIID_W     = 11,
    parameter int ADDR_W     = 64
) (
    input  logic                         i_clk,
    input  logic                         ni_rst,
    input  logic                         i_domain_ie,
    input  logic [NR_SRC-1:0]            i_pend,
    input  logic [NR_SRC-1:0]            i_en,
    input  logic [NR_SRC*HART_IDX_W-1:0] i_target_hi,
    input  logic [NR_SRC*EIID_W-1:0]     i_target_eiid,
    input  logic [ADDR_W-1:0]            i_msi_base,
    input  logic                         i_genmsi_wr,
    input  logic [HART_IDX_W-1:0]        i_genmsi_hi,
    input  logic [EIID_W-1:0]            i_genmsi_eiid,
    output logic                         o_genmsi_busy,
    output logic                         o_msi_valid,
    input  logic                         i_msi_ready,
    output logic [ADDR_W-1:0]            o_msi_addr,
    output logic [31:0]                  o_msi_data,
    output logic                         o_clrip_valid,
    output logic [$clog2(NR_SRC)-1:0]    o_clrip_idx
);

    localparam int IDX_W = $clog2(NR_SRC);

    msi_sched_state_e state, state_next;

    logic [NR_SRC-1:0] req;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  rr_ptr;
    msi_req_t          pick;
    logic              pick_valid;
    logic              src_pick;
    logic              issue_go;
    logic              zero_clr;
    logic              done;
    hart_index_t       gen_hi;
    eiid_t             gen_eiid;
    logic              cur_is_gen;
    logic [9:0]        cur_src;

    // Source 0 does not exist; mask it out of the request vector.
    assign req = i_pend & i_en & {NR_SRC{i_domain_ie}} & {{(NR_SRC-1){1'b1}}, 1'b0};

    aplic_rr_picker #(
        .NR_SRC (NR_SRC),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Candidate for this cycle: a full genmsi slot beats any source.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        if (o_genmsi_busy) begin
            pick.hi     = gen_hi;
            pick.eiid   = gen_eiid;
            pick.is_gen = 1'b1;
            pick_valid  = 1'b1;
        end else if (pick_found) begin
            pick.hi    = i_target_hi[int'(pick_idx)*HART_IDX_W +: HART_IDX_W];
            pick.eiid  = i_target_eiid[int'(pick_idx)*EIID_W +: EIID_W];
            pick.src   = 10'(pick_idx);
            pick_valid = 1'b1;
        end
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        state_next = state;
        issue_go   = 1'b0;
        zero_clr   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    // A source targeting EIID 0 is never delivered, only cleared.
                    if (!pick.is_gen && (pick.eiid == '0)) begin
                        zero_clr = 1'b1;
                    end else begin
                        issue_go   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_msi_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign src_pick = (state == IDLE) && pick_valid && !pick.is_gen;

    // State register.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef APLIC_MSI_SCHED_RR_EN
    // Rotating pointer: restart just after the last source served, skipping 0.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            rr_ptr <= IDX_W'(1);
        end else if (src_pick) begin
            rr_ptr <= (pick_idx == IDX_W'(NR_SRC - 1)) ? IDX_W'(1) : pick_idx + IDX_W'(1);
        end
    end
`else
    assign rr_ptr = IDX_W'(1);
`endif

    // MSI request, clear pulse and genmsi slot registers.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            o_msi_valid   <= 1'b0;
            o_msi_addr    <= '0;
            o_msi_data    <= '0;
            o_clrip_valid <= 1'b0;
            o_clrip_idx   <= '0;
            o_genmsi_busy <= 1'b0;
            gen_hi        <= '0;
            gen_eiid      <= '0;
            cur_is_gen    <= 1'b0;
            cur_src       <= '0;
        end else begin
            o_clrip_valid <= 1'b0;
            if (issue_go) begin
                o_msi_valid <= 1'b1;
                o_msi_addr  <= i_msi_base + (ADDR_W'(pick.hi) << MSI_PAGE_SHIFT);
                o_msi_data  <= 32'(pick.eiid);
                cur_is_gen  <= pick.is_gen;
                cur_src     <= pick.src;
            end
            if (zero_clr) begin
                o_clrip_valid <= 1'b1;
                o_clrip_idx   <= IDX_W'(pick.src);
            end
            if (done) begin
                o_msi_valid <= 1'b0;
                if (cur_is_gen) begin
                    o_genmsi_busy <= 1'b0;
                end else begin
                    o_clrip_valid <= 1'b1;
                    o_clrip_idx   <= IDX_W'(cur_src);
                end
            end
            // Busy is still set on the completion cycle, so a write there is dropped.
            if (i_genmsi_wr && !o_genmsi_busy) begin
                o_genmsi_busy <= 1'b1;
                gen_hi        <= i_genmsi_hi;
                gen_eiid      <= i_genmsi_eiid;
            end
        end
    end

endmodule

// File: tb/tb_aplic_msi_sched.sv
// Self-checking bench for aplic_msi_sched: directed scenarios followed by a
// randomized phase, all compared against a cycle-level transaction model.
module tb_aplic_msi_sched;

    localparam int NR_SRC = 32;
    localparam int HW     = 14;
    localparam int EW     = 11;
    localparam int AW     = 64;
    localparam int IW     = $clog2(NR_SRC);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   domain_ie;
    logic [NR_SRC-1:0]      pend;
    logic [NR_SRC-1:0]      en;
    logic [NR_SRC*HW-1:0]   thi;
    logic [NR_SRC*EW-1:0]   teiid;
    logic [AW-1:0]          base;
    logic                   gwr;
    logic [HW-1:0]          ghi;
    logic [EW-1:0]          geiid;
    logic                   busy;
    logic                   mvalid;
    logic                   ready;
    logic [AW-1:0]          maddr;
    logic [31:0]            mdata;
    logic                   clr_v;
    logic [IW-1:0]          clr_idx;

    always #5 clk = ~clk;

    aplic_msi_sched #(
        .NR_SRC     (NR_SRC),
        .HART_IDX_W (HW),
        .EIID_W     (EW),
        .ADDR_W     (AW)
    ) dut (
        .i_clk         (clk),
        .ni_rst        (rst_n),
        .i_domain_ie   (domain_ie),
        .i_pend        (pend),
        .i_en          (en),
        .i_target_hi   (thi),
        .i_target_eiid (teiid),
        .i_msi_base    (base),
        .i_genmsi_wr   (gwr),
        .i_genmsi_hi   (ghi),
        .i_genmsi_eiid (geiid),
        .o_genmsi_busy (busy),
        .o_msi_valid   (mvalid),
        .i_msi_ready   (ready),
        .o_msi_addr    (maddr),
        .o_msi_data    (mdata),
        .o_clrip_valid (clr_v),
        .o_clrip_idx   (clr_idx)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be after the next clock edge.
    bit          m_issue, m_valid, m_clr, m_busy, m_cur_gen;
    logic [63:0] m_addr;
    logic [31:0] m_data;
    int          m_clr_idx, m_ghi, m_geiid, m_ptr, m_cur_src;

    logic [31:0] hs_q[$];
    int          valid_cnt = 0;
    int          clr_cnt = 0;
    int          last_clr = 0;
    bit          honour = 1'b1;

    function automatic int tgt_hi(input int k);
        return int'(thi[k*HW +: HW]);
    endfunction

    function automatic int tgt_eiid(input int k);
        return int'(teiid[k*EW +: EW]);
    endfunction

    task automatic set_tgt(input int k, input int hi, input int e);
        thi[k*HW +: HW]   = HW'(hi);
        teiid[k*EW +: EW] = EW'(e);
    endtask

    // Walk sources 1..NR_SRC-1 cyclically from the pointer; 0 means none.
    function automatic int model_pick();
        int span;
        int k;
        span = NR_SRC - 1;
        for (int off = 0; off < span; off++) begin
            k = ((m_ptr - 1 + off) % span) + 1;
            if (domain_ie && pend[k] && en[k]) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_issue = 0; m_valid = 0; m_clr = 0; m_busy = 0; m_cur_gen = 0;
        m_addr = '0; m_data = '0; m_clr_idx = 0; m_ghi = 0; m_geiid = 0;
        m_ptr = 1; m_cur_src = 0;
    endtask

    task automatic model_step();
        bit was_busy;
        int k;
        was_busy = m_busy;
        m_clr = 0;
        if (!m_issue) begin
            if (m_busy) begin
                m_issue = 1; m_valid = 1; m_cur_gen = 1;
                m_addr = base + (64'(m_ghi) << 12);
                m_data = 32'(m_geiid);
            end else begin
                k = model_pick();
                if (k != 0) begin
`ifdef APLIC_MSI_SCHED_RR_EN
                    m_ptr = (k == NR_SRC - 1) ? 1 : k + 1;
`endif
                    if (tgt_eiid(k) == 0) begin
                        m_clr = 1; m_clr_idx = k;
                    end else begin
                        m_issue = 1; m_valid = 1; m_cur_gen = 0; m_cur_src = k;
                        m_addr = base + (64'(tgt_hi(k)) << 12);
                        m_data = 32'(tgt_eiid(k));
                    end
                end
            end
        end else if (ready) begin
            m_issue = 0; m_valid = 0;
            if (m_cur_gen) m_busy = 0;
            else begin m_clr = 1; m_clr_idx = m_cur_src; end
        end
        if (gwr && !was_busy) begin
            m_busy = 1; m_ghi = int'(ghi); m_geiid = int'(geiid);
        end
    endtask

    // One clock: predict, clock, compare, then act as the pending logic.
    task automatic cycle();
        if (mvalid && ready) hs_q.push_back(mdata);
        model_step();
        @(posedge clk);
        #1;
        check("msi_valid", mvalid, m_valid);
        if (m_valid) begin
            check("msi_addr", maddr, m_addr);
            check("msi_data", mdata, m_data);
        end
        check("clrip_valid", clr_v, m_clr);
        if (m_clr) check("clrip_idx", clr_idx, m_clr_idx);
        check("genmsi_busy", busy, m_busy);
        if (mvalid) valid_cnt++;
        if (clr_v) begin
            clr_cnt++;
            last_clr = int'(clr_idx);
            if (honour) pend[clr_idx] = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, mvalid, 0);
        check({tag, "_addr"}, maddr, 0);
        check({tag, "_data"}, mdata, 0);
        check({tag, "_clr"}, clr_v, 0);
        check({tag, "_clridx"}, clr_idx, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    int vc, cc;
    int exp_order[4];

    initial begin
        domain_ie = 1'b1; pend = '0; en = '0; thi = '0; teiid = '0;
        base = 64'h2800_0000; gwr = 1'b0; ghi = '0; geiid = '0; ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin order with clears ignored by the pending logic.
        honour = 1'b0;
        for (int k = 1; k <= 4; k++) set_tgt(k, k, k);
        pend[1] = 1; pend[3] = 1; pend[4] = 1;
        en[1] = 1; en[3] = 1; en[4] = 1;
        hs_q.delete();
        repeat (10) cycle();
`ifdef APLIC_MSI_SCHED_RR_EN
        exp_order = '{1, 3, 4, 1};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        check("rr_count_ge4", (hs_q.size() >= 4), 1);
        for (int i = 0; i < 4 && i < hs_q.size(); i++) check("rr_order", hs_q[i], exp_order[i]);
        pend = '0; honour = 1'b1;
        repeat (4) cycle();

        // Single source delivery.
        set_tgt(5, 3, 'h2A);
        pend[5] = 1; en[5] = 1; ready = 1;
        cycle();
        check("single_valid", mvalid, 1);
        check("single_addr", maddr, 64'h2800_3000);
        check("single_data", mdata, 32'h2A);
        cycle();
        check("single_clr", clr_v, 1);
        check("single_clridx", clr_idx, 5);
        cycle();

        // Backpressure: request held stable, one clear after acceptance.
        pend[5] = 1; ready = 0;
        cycle();
        check("bp_valid0", mvalid, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_valid", mvalid, 1);
            check("bp_addr", maddr, 64'h2800_3000);
            check("bp_data", mdata, 32'h2A);
        end
        cc = clr_cnt;
        ready = 1;
        repeat (3) cycle();
        check("bp_one_clr", clr_cnt - cc, 1);

        // Genmsi overtakes an eligible source; writes while busy are dropped.
        hs_q.delete();
        pend[5] = 1; ready = 0;
        cycle();
        set_tgt(2, 1, 9);
        pend[2] = 1; en[2] = 1;
        gwr = 1; ghi = 0; geiid = 7;
        cycle();
        gwr = 0;
        check("gen_busy_set", busy, 1);
        ready = 1;
        cycle();
        cycle();
        check("gen_first_data", mdata, 7);
        check("gen_first_addr", maddr, 64'h2800_0000);
        ready = 0; gwr = 1; ghi = 5; geiid = 'h55;
        cycle();
        ready = 1; geiid = 'h66;
        cycle();
        gwr = 0;
        check("gen_busy_clear", busy, 0);
        cycle();
        check("gen_then_src_data", mdata, 9);
        repeat (3) cycle();
        check("gen_hs_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check("gen_hs0", hs_q[0], 'h2A);
            check("gen_hs1", hs_q[1], 7);
            check("gen_hs2", hs_q[2], 9);
        end

        // EIID 0 target: cleared, never sent.
        set_tgt(7, 4, 0);
        pend[7] = 1; en[7] = 1; ready = 1;
        vc = valid_cnt; cc = clr_cnt;
        repeat (4) cycle();
        check("eiid0_no_valid", valid_cnt - vc, 0);
        check("eiid0_one_clr", clr_cnt - cc, 1);
        check("eiid0_clridx", last_clr, 7);

        // Reset in the middle of an outstanding write.
        set_tgt(9, 2, 'h33);
        pend[9] = 1; en[9] = 1; ready = 0;
        gwr = 1; ghi = 1; geiid = 3;
        cycle();
        gwr = 0;
        cycle();
        check("rst_pre_valid", mvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        pend = '0;
        set_tgt(2, 0, 'h12);
        set_tgt(20, 0, 'h14);
        pend[2] = 1; pend[20] = 1; en[2] = 1; en[20] = 1;
        ready = 1;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post_rst_busy", busy, 0);
        check("post_rst_pick", mdata, 'h12);
        repeat (6) cycle();

        // Randomized traffic.
        base = {$urandom, $urandom} & ~64'hFFF;
        for (int k = 0; k < NR_SRC; k++)
            set_tgt(k, int'($urandom), ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 2047)));
        en = $urandom;
        for (int n = 0; n < 3000; n++) begin
            ready = ($urandom % 3) != 0;
            domain_ie = ($urandom % 16) != 0;
            if ($urandom % 4 == 0) pend[$urandom_range(0, NR_SRC - 1)] = 1'b1;
            if ($urandom % 16 == 0) en[$urandom_range(0, NR_SRC - 1)] ^= 1'b1;
            gwr = ($urandom % 12) == 0;
            ghi = HW'($urandom);
            geiid = EW'($urandom);
            if ($urandom % 64 == 0) base = {$urandom, $urandom} & ~64'hFFF;
            cycle();
        end
        gwr = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
